piso_shift_register_param: RTL and testbench
============================================

Name: piso_shift_register_param

Overview:
Parametrised parallel-in/serial-out shift register with a valid/ready load handshake, consumer-controlled shift pacing, and selectable bit order. A WIDTH-bit word is captured, then presented one bit at a time on a registered serial output with framing flags. Back-to-back words can stream with no idle cycle. Serves as the generic serialiser for UART/SPI-style transmit paths and replaces fixed 4-bit PISO instances.

Parameters:
WIDTH, 8, word width in bits; legal range 2..64.
MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
IDLE_LEVEL, 1'b0, value driven on serial_out when no bit is presented.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous reset, active-low.
load_valid  input  1  parallel_in holds a word to send.
load_ready  output  1  block accepts a word at this edge; combinational.
parallel_in  input  WIDTH  word to serialise; sampled only on acceptance.
shift_en  input  1  consumer takes the presented bit at this edge.
serial_out  output  1  current serial bit; registered.
serial_valid  output  1  serial_out holds a valid bit; registered.
frame_start  output  1  presented bit is the first bit of a word; registered.
frame_last  output  1  presented bit is the last bit of a word; registered.
busy  output  1  equals serial_valid.

Behaviour:
- Reset (rst_n=0 at a clk edge): serial_out=IDLE_LEVEL, serial_valid=0, frame_start=0, frame_last=0, internal shift register and bit counter cleared, FSM=IDLE. Reset overrides all other inputs, including mid-word; the partial word is discarded.
- FSM: IDLE (serial_valid=0) and SHIFT (serial_valid=1). The internal counter tracks bits remaining, width $clog2(WIDTH)+1.
- load_ready = rst_n && (!serial_valid || (frame_last && shift_en)).
- Acceptance happens when load_valid && load_ready at an edge. Next cycle: serial_out = first bit (parallel_in[WIDTH-1] if MSB_FIRST, else parallel_in[0]), serial_valid=1, frame_start=1, frame_last=0. The remaining WIDTH-1 bits are held internally. Latency from acceptance to first bit is 1 cycle.
- In SHIFT, each edge with shift_en=1 consumes the presented bit and presents the next one. shift is left for MSB_FIRST, right otherwise. frame_start drops after the first consume.
- frame_last=1 exactly while the WIDTH-th bit is presented.
- shift_en=0 stalls the stream: serial_out and all flags hold, for any number of cycles.
- Consuming the last bit:
  - with an accepted load at the same edge: the new word's first bit is presented next cycle (frame_start=1, no gap).
  - otherwise: return to IDLE; serial_out=IDLE_LEVEL, flags 0.
- load_valid while busy and not on the last-bit consume: ignored (load_ready=0). The current word is not corrupted, and parallel_in changes have no effect.
- shift_en in IDLE: ignored.
- A word produces exactly WIDTH consumes. Bit order is strictly the MSB_FIRST order, with no repeated or dropped bits.
- Fully synchronous design, with no latches and no delays in RTL.

Test Plan:
1. WIDTH=4, MSB_FIRST=1; reset, load 4'b1101, shift_en=1 continuously -> serial_out 1,1,0,1 on the 4 cycles after acceptance; frame_start on bit 1, frame_last on bit 4; then serial_valid=0, serial_out=0.
2. Same word with MSB_FIRST=0 -> serial_out 1,0,1,1.
3. WIDTH=8, load 8'hA5, shift_en low for 3 cycles after the second bit -> second bit (0) held for 4 cycles; full sequence is 1,0,1,0,0,1,0,1 with no loss.
4. WIDTH=4, load_valid held high with words 4'b1001 then 4'b0110 -> load_ready pulses on the last-bit consume; 8 consecutive valid bits 1,0,0,1,0,1,1,0; frame_start on bits 1 and 5; no idle cycle between words.
5. Assert rst_n=0 during the 3rd bit of 8'hFF -> next cycle serial_valid=0, serial_out=IDLE_LEVEL; a new load of 8'h01 then yields 0,0,0,0,0,0,0,1.
6. load_valid with a different word mid-frame (not the last bit) -> load_ready=0; the original word completes unaltered.

Source files
------------

// File: rtl/piso_shift_register_param.sv
// Parametrised parallel-in/serial-out shift register with a valid/ready load
// handshake, consumer-paced shifting, framing flags and selectable bit order.
module piso_shift_register_param #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bits_left;
  logic             accept;
  logic             consume;

  // Bit that leaves the word next, according to the configured order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign serial_valid = (state == SHIFT);
  assign busy         = serial_valid;
  // A new word may enter while idle, or on the very edge the last bit is taken.
  assign load_ready   = rst_n && (!serial_valid || (frame_last && shift_en));
  assign accept       = load_valid && load_ready;
  assign consume      = serial_valid && shift_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bits_left   <= '0;
      serial_out  <= IDLE_LEVEL;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end else if (accept) begin
      state       <= SHIFT;
      serial_out  <= head_bit(parallel_in);
      shreg       <= advance(parallel_in);
      bits_left   <= CNT_W'(WIDTH - 1);
      frame_start <= 1'b1;
      frame_last  <= 1'b0;
    end else if (consume) begin
      if (frame_last) begin
        state       <= IDLE;
        shreg       <= '0;
        bits_left   <= '0;
        serial_out  <= IDLE_LEVEL;
        frame_start <= 1'b0;
        frame_last  <= 1'b0;
      end else begin
        // bits_left counts bits not yet presented; the final one is flagged.
        serial_out  <= head_bit(shreg);
        shreg       <= advance(shreg);
        bits_left   <= bits_left - CNT_W'(1);
        frame_start <= 1'b0;
        frame_last  <= (bits_left == CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_register_param.sv
// Bench for piso_shift_register_param: three configurations checked every cycle
// against a word/bit-index reference model, plus directed framing scenarios.
module tb_piso_shift_register_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, load_valid, shift_en;
  logic [3:0] pin4;
  logic [7:0] pin8;
  logic [2:0] so, sv, fs, fl, bz, lr;

  int n_checks = 0;
  int n_errs   = 0;

  int   mw[3]    = '{4, 4, 8};
  bit   mmsb[3]  = '{1'b1, 1'b0, 1'b1};
  logic midle[3] = '{1'b0, 1'b1, 1'b0};

  bit          mact[3];
  int          mpos[3];
  logic [63:0] mword[3];

  logic [63:0] cap[3];
  logic [63:0] capfs[3];
  int          capn[3];

  piso_shift_register_param #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u4m (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr[0]),
    .parallel_in(pin4), .shift_en(shift_en), .serial_out(so[0]), .serial_valid(sv[0]),
    .frame_start(fs[0]), .frame_last(fl[0]), .busy(bz[0]));

  piso_shift_register_param #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u4l (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr[1]),
    .parallel_in(pin4), .shift_en(shift_en), .serial_out(so[1]), .serial_valid(sv[1]),
    .frame_start(fs[1]), .frame_last(fl[1]), .busy(bz[1]));

  piso_shift_register_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr[2]),
    .parallel_in(pin8), .shift_en(shift_en), .serial_out(so[2]), .serial_valid(sv[2]),
    .frame_start(fs[2]), .frame_last(fl[2]), .busy(bz[2]));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 3; i++) begin
      cap[i] = '0; capfs[i] = '0; capn[i] = 0;
    end
  endtask

  // One clock: compare all outputs to the model at negedge, then advance the model.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      logic e_so, e_sv, e_fs, e_fl, e_lr;
      int   idx;
      if (mact[i]) begin
        idx  = mmsb[i] ? (mw[i] - 1 - mpos[i]) : mpos[i];
        e_so = mword[i][idx];
        e_sv = 1'b1;
        e_fs = (mpos[i] == 0);
        e_fl = (mpos[i] == mw[i] - 1);
      end else begin
        e_so = midle[i];
        e_sv = 1'b0;
        e_fs = 1'b0;
        e_fl = 1'b0;
      end
      e_lr = rst_n && (!mact[i] || (e_fl && shift_en));
      check_eq($sformatf("u%0d serial_out", i),   64'(so[i]), 64'(e_so));
      check_eq($sformatf("u%0d serial_valid", i), 64'(sv[i]), 64'(e_sv));
      check_eq($sformatf("u%0d frame_start", i),  64'(fs[i]), 64'(e_fs));
      check_eq($sformatf("u%0d frame_last", i),   64'(fl[i]), 64'(e_fl));
      check_eq($sformatf("u%0d busy", i),         64'(bz[i]), 64'(e_sv));
      check_eq($sformatf("u%0d load_ready", i),   64'(lr[i]), 64'(e_lr));
      if (sv[i] === 1'b1 && shift_en) begin
        cap[i]   = (cap[i] << 1) | 64'(so[i]);
        capfs[i] = (capfs[i] << 1) | 64'(fs[i]);
        capn[i]++;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      logic [63:0] nw;
      nw = (i < 2) ? 64'(pin4) : 64'(pin8);
      if (!rst_n) mact[i] = 1'b0;
      else if (mact[i] && shift_en && mpos[i] == mw[i] - 1) begin
        if (load_valid) begin mword[i] = nw; mpos[i] = 0; end
        else mact[i] = 1'b0;
      end else if (mact[i] && shift_en) mpos[i]++;
      else if (!mact[i] && load_valid) begin
        mact[i] = 1'b1; mword[i] = nw; mpos[i] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; shift_en = 1'b0; pin4 = '0; pin8 = '0;
    for (int i = 0; i < 3; i++) begin mact[i] = 1'b0; mpos[i] = 0; mword[i] = '0; end
    @(posedge clk); #1;
    step();
    rst_n = 1'b1;
    check_eq("reset serial_out u4m", 64'(so[0]), 64'(1'b0));
    check_eq("reset serial_out u4l", 64'(so[1]), 64'(1'b1));

    // 1101 streamed continuously in both bit orders.
    clear_cap();
    load_valid = 1'b1; pin4 = 4'b1101; shift_en = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (4) step();
    check_eq("msb order bits", cap[0], 64'b1101);
    check_eq("lsb order bits", cap[1], 64'b1011);
    check_eq("msb bit count", 64'(capn[0]), 64'd4);
    check_eq("msb frame_start pos", capfs[0], 64'b1000);
    check_eq("idle valid after word", 64'(sv[0]), 64'd0);
    check_eq("idle level u4m", 64'(so[0]), 64'd0);
    check_eq("idle level u4l", 64'(so[1]), 64'd1);

    // A5 with a 3-cycle stall after the second bit.
    do_reset();
    clear_cap();
    load_valid = 1'b1; pin8 = 8'hA5; shift_en = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    shift_en = 1'b0;
    repeat (3) begin
      step();
      check_eq("stall holds bit", 64'(so[2]), 64'd0);
      check_eq("stall holds valid", 64'(sv[2]), 64'd1);
    end
    shift_en = 1'b1;
    repeat (7) step();
    check_eq("stalled word bits", cap[2], 64'hA5);
    check_eq("stalled word count", 64'(capn[2]), 64'd8);

    // Back-to-back words; new parallel_in mid-frame must be ignored.
    do_reset();
    clear_cap();
    load_valid = 1'b1; pin4 = 4'b1001; shift_en = 1'b1;
    step();
    pin4 = 4'b0110;
    repeat (3) begin
      check_eq("mid-frame load_ready", 64'(lr[0]), 64'd0);
      step();
    end
    check_eq("last-bit load_ready", 64'(lr[0]), 64'd1);
    step();
    load_valid = 1'b0;
    repeat (4) step();
    check_eq("b2b bits msb", cap[0], 64'b10010110);
    check_eq("b2b bits lsb", cap[1], 64'b10010110);
    check_eq("b2b no gap count", 64'(capn[0]), 64'd8);
    check_eq("b2b frame_start", capfs[0], 64'b10001000);

    // Reset in the middle of a word, then a fresh word.
    do_reset();
    clear_cap();
    load_valid = 1'b1; pin8 = 8'hFF; shift_en = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("mid-word reset valid", 64'(sv[2]), 64'd0);
    check_eq("mid-word reset out", 64'(so[2]), 64'd0);
    clear_cap();
    load_valid = 1'b1; pin8 = 8'h01;
    step();
    load_valid = 1'b0;
    repeat (8) step();
    check_eq("post-reset word", cap[2], 64'h01);
    check_eq("post-reset count", 64'(capn[2]), 64'd8);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rst_n      = ($urandom_range(0, 49) != 0);
      load_valid = ($urandom_range(0, 1) != 0);
      shift_en   = ($urandom_range(0, 3) != 0);
      pin4       = 4'($urandom);
      pin8       = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
